// File: rtl/ipl_event_queue.sv
// rtl/ipl_event_queue.sv - stability-filtered interrupt level change queue popped by Pi status reads
// Levels are qualified on c7m edges; each change is queued and read back through rd_data.
module ipl_event_queue #(
  parameter int IPL_W      = 3,
  parameter int DEPTH      = 64,
  parameter int STABLE_CNT = 3,
  parameter int COALESCE   = 0
) (
  input  logic             c200m,
  input  logic             reset,
  input  logic             c7m,
  input  logic [IPL_W-1:0] ipl_n,
  input  logic             pi_rd,
  input  logic             rd_sel,
  output logic [15:0]      rd_data,
  output logic             pending,
  output logic [8:0]       fill,
  output logic             overflow
);

  localparam int             PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0]  LAST     = PW'(DEPTH - 1);
  localparam logic [8:0]     FULL_CNT = 9'(DEPTH);

  logic [IPL_W-1:0] ipl_m, ipl_q, ipl_s;
  logic [2:0]       c7m_s;
  logic [1:0]       rd_s;
  logic             c7m_rise, rd_rise, rd_req;
  logic [IPL_W-1:0] hist [STABLE_CNT];
  logic [IPL_W-1:0] q_lvl, last_lvl;
  logic [IPL_W-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, wr_prev;
  logic [7:0]       evt_cnt;
  logic             all_eq, evt, empty, full, room;
  logic             do_push, do_pop, do_coal, do_drop;
  logic [8:0]       fill_nx;
  logic [15:0]      rd_word;

  assign ipl_s    = ~ipl_q;
  assign c7m_rise = !c7m_s[2] && c7m_s[1];
  assign rd_rise  = !rd_s[1] && rd_s[0];
  assign rd_req   = rd_rise && rd_sel;

  always_comb begin
    all_eq = 1'b1;
    for (int i = 0; i < STABLE_CNT; i++)
      if (hist[i] != ipl_s) all_eq = 1'b0;
  end

  assign evt   = (q_lvl != last_lvl);
  assign empty = (fill == 9'd0);
  assign full  = (fill == FULL_CNT);

  // A pop in the same cycle frees a slot, so a full queue still accepts the event.
  assign do_pop  = rd_req && !empty;
  assign room    = !full || do_pop;
  assign do_push = evt && room;
  assign do_coal = evt && !room && (COALESCE != 0);
  assign do_drop = evt && !room && (COALESCE == 0);
  assign fill_nx = fill + 9'(do_push) - 9'(do_pop);
  assign wr_prev = (wr_ptr == '0) ? LAST : wr_ptr - PW'(1);

  always_comb begin
    rd_word               = '0;
    rd_word[15 -: IPL_W]  = empty ? q_lvl : mem[rd_ptr];
    rd_word[9]            = empty;
    rd_word[8]            = overflow;
    rd_word[7:0]          = evt_cnt;
  end

  always_ff @(posedge c200m) begin
    if (do_push)
      mem[wr_ptr] <= q_lvl;
    else if (do_coal)
      mem[wr_prev] <= q_lvl;
  end

  always_ff @(posedge c200m or posedge reset) begin
    if (reset) begin
      ipl_m    <= '0;
      ipl_q    <= '0;
      c7m_s    <= '0;
      rd_s     <= '0;
      for (int i = 0; i < STABLE_CNT; i++) hist[i] <= '0;
      q_lvl    <= '0;
      last_lvl <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      evt_cnt  <= '0;
      fill     <= '0;
      pending  <= 1'b0;
      overflow <= 1'b0;
      rd_data  <= '0;
    end else begin
      ipl_m <= ipl_n;
      ipl_q <= ipl_m;
      c7m_s <= {c7m_s[1:0], c7m};
      rd_s  <= {rd_s[0], pi_rd};
      if (c7m_rise) begin
        hist[0] <= ipl_s;
        for (int i = 1; i < STABLE_CNT; i++) hist[i] <= hist[i-1];
      end
      if (all_eq) q_lvl <= ipl_s;
      if (evt) begin
        last_lvl <= q_lvl;
        evt_cnt  <= evt_cnt + 8'd1;
      end
      if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
      fill    <= fill_nx;
      pending <= (fill_nx != 9'd0);
      if (rd_req) rd_data <= rd_word;
      if (do_drop)
        overflow <= 1'b1;
      else if (rd_req)
        overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ipl_event_queue.sv
// tb/tb_ipl_event_queue.sv - directed bench for ipl_event_queue, drop and coalesce variants side by side
// Both instances share stimulus; DEPTH=4 so the full-queue cases are reachable quickly.
module tb_ipl_event_queue;

  logic        clk = 1'b0;
  logic        reset, c7m, pi_rd, rd_sel;
  logic [2:0]  ipl_n;
  logic [15:0] rd_data0, rd_data1;
  logic        pending0, pending1, overflow0, overflow1;
  logic [8:0]  fill0, fill1;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  ipl_event_queue #(.IPL_W(3), .DEPTH(4), .STABLE_CNT(3), .COALESCE(0)) dut0 (
    .c200m(clk), .reset(reset), .c7m(c7m), .ipl_n(ipl_n), .pi_rd(pi_rd), .rd_sel(rd_sel),
    .rd_data(rd_data0), .pending(pending0), .fill(fill0), .overflow(overflow0));

  ipl_event_queue #(.IPL_W(3), .DEPTH(4), .STABLE_CNT(3), .COALESCE(1)) dut1 (
    .c200m(clk), .reset(reset), .c7m(c7m), .ipl_n(ipl_n), .pi_rd(pi_rd), .rd_sel(rd_sel),
    .rd_data(rd_data1), .pending(pending1), .fill(fill1), .overflow(overflow1));

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One c7m period of 16 cycles; rd_at > 0 raises pi_rd that many cycles after c7m rises.
  task automatic pulse(input int rd_at);
    c7m = 1'b1;
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      if (rd_at > 0 && i == rd_at) pi_rd = 1'b1;
      if (rd_at > 0 && i == rd_at + 3) pi_rd = 1'b0;
    end
    @(negedge clk);
    c7m = 1'b0;
    tick(8);
  endtask

  task automatic set_level(input logic [2:0] lvl, input int n);
    ipl_n = ~lvl;
    tick(2);
    repeat (n) pulse(0);
  endtask

  task automatic rd(input logic sel);
    rd_sel = sel;
    pi_rd  = 1'b1;
    tick(3);
    pi_rd  = 1'b0;
    tick(3);
    rd_sel = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    ipl_n = 3'b111; c7m = 1'b0; pi_rd = 1'b0; rd_sel = 1'b0; reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(3);
  endtask

  task automatic test_reset();
    do_reset();
    if (rd_data0 !== 16'h0) begin n_bad++; $display("FAIL rst_rd_data got %h want 0000", rd_data0); end
    n_cmp++;
    if (pending0 !== 1'b0) begin n_bad++; $display("FAIL rst_pending got %b want 0", pending0); end
    n_cmp++;
    if (fill0 !== 9'd0) begin n_bad++; $display("FAIL rst_fill got %0d want 0", fill0); end
    n_cmp++;
    if (overflow0 !== 1'b0) begin n_bad++; $display("FAIL rst_overflow got %b want 0", overflow0); end
    n_cmp++;
    set_level(3'd1, 3);
    rd(1'b1);
    if (rd_data0 !== 16'h2001) begin n_bad++; $display("FAIL pre_rst_read got %h want 2001", rd_data0); end
    n_cmp++;
    set_level(3'd3, 3);
    if (fill0 !== 9'd1) begin n_bad++; $display("FAIL pre_rst_fill got %0d want 1", fill0); end
    n_cmp++;
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    if (rd_data0 !== 16'h0) begin n_bad++; $display("FAIL async_rd_data got %h want 0000", rd_data0); end
    n_cmp++;
    if (pending0 !== 1'b0) begin n_bad++; $display("FAIL async_pending got %b want 0", pending0); end
    n_cmp++;
    if (fill0 !== 9'd0) begin n_bad++; $display("FAIL async_fill got %0d want 0", fill0); end
    n_cmp++;
    if (overflow0 !== 1'b0) begin n_bad++; $display("FAIL async_overflow got %b want 0", overflow0); end
    n_cmp++;
    @(negedge clk);
    reset = 1'b0;
    tick(3);
    repeat (3) pulse(0);
    if (fill0 !== 9'd1) begin n_bad++; $display("FAIL post_rst_event fill got %0d want 1", fill0); end
    n_cmp++;
  endtask

  task automatic test_basic();
    do_reset();
    set_level(3'b010, 2);
    if (fill0 !== 9'd0) begin n_bad++; $display("FAIL basic_two_edges fill got %0d want 0", fill0); end
    n_cmp++;
    pulse(0);
    if (fill0 !== 9'd1) begin n_bad++; $display("FAIL basic_fill got %0d want 1", fill0); end
    n_cmp++;
    if (pending0 !== 1'b1) begin n_bad++; $display("FAIL basic_pending got %b want 1", pending0); end
    n_cmp++;
    rd(1'b0);
    if (fill0 !== 9'd1 || rd_data0 !== 16'h0) begin
      n_bad++; $display("FAIL basic_unselected fill %0d rd_data %h want 1 0000", fill0, rd_data0);
    end
    n_cmp++;
    rd(1'b1);
    if (rd_data0 !== 16'h4001) begin n_bad++; $display("FAIL basic_read got %h want 4001", rd_data0); end
    n_cmp++;
    if (pending0 !== 1'b0 || fill0 !== 9'd0) begin
      n_bad++; $display("FAIL basic_after_pop pending %b fill %0d want 0 0", pending0, fill0);
    end
    n_cmp++;
  endtask

  task automatic test_glitch();
    do_reset();
    set_level(3'b100, 2);
    set_level(3'b000, 3);
    if (fill0 !== 9'd0) begin n_bad++; $display("FAIL glitch_fill got %0d want 0", fill0); end
    n_cmp++;
    rd(1'b1);
    if (rd_data0 !== 16'h0200) begin n_bad++; $display("FAIL glitch_empty_read got %h want 0200", rd_data0); end
    n_cmp++;
  endtask

  task automatic test_overflow();
    logic [15:0] exp [5];
    exp = '{16'h2106, 16'h4006, 16'h6006, 16'h8006, 16'hC206};
    do_reset();
    for (int l = 1; l <= 6; l++) set_level(3'(l), 3);
    if (fill0 !== 9'd4) begin n_bad++; $display("FAIL ovf_fill got %0d want 4", fill0); end
    n_cmp++;
    if (overflow0 !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got %b want 1", overflow0); end
    n_cmp++;
    for (int r = 0; r < 5; r++) begin
      rd(1'b1);
      if (rd_data0 !== exp[r]) begin n_bad++; $display("FAIL ovf_read%0d got %h want %h", r, rd_data0, exp[r]); end
      n_cmp++;
    end
    if (overflow0 !== 1'b0) begin n_bad++; $display("FAIL ovf_cleared got %b want 0", overflow0); end
    n_cmp++;
  endtask

  task automatic test_coalesce();
    logic [15:0] exp [5];
    exp = '{16'h2006, 16'h4006, 16'h6006, 16'hC006, 16'hC206};
    do_reset();
    for (int l = 1; l <= 6; l++) set_level(3'(l), 3);
    if (fill1 !== 9'd4) begin n_bad++; $display("FAIL coal_fill got %0d want 4", fill1); end
    n_cmp++;
    if (overflow1 !== 1'b0) begin n_bad++; $display("FAIL coal_flag got %b want 0", overflow1); end
    n_cmp++;
    for (int r = 0; r < 5; r++) begin
      rd(1'b1);
      if (rd_data1 !== exp[r]) begin n_bad++; $display("FAIL coal_read%0d got %h want %h", r, rd_data1, exp[r]); end
      n_cmp++;
    end
  endtask

  task automatic test_collision();
    logic [15:0] exp [4];
    exp = '{16'h4005, 16'h6005, 16'h8005, 16'hA005};
    do_reset();
    for (int l = 1; l <= 4; l++) set_level(3'(l), 3);
    if (fill0 !== 9'd4) begin n_bad++; $display("FAIL coll_prefill got %0d want 4", fill0); end
    n_cmp++;
    set_level(3'd5, 2);
    rd_sel = 1'b1;
    pulse(3);
    rd_sel = 1'b0;
    if (rd_data0 !== 16'h2004) begin n_bad++; $display("FAIL coll_full_read got %h want 2004", rd_data0); end
    n_cmp++;
    if (fill0 !== 9'd4 || overflow0 !== 1'b0) begin
      n_bad++; $display("FAIL coll_full fill %0d overflow %b want 4 0", fill0, overflow0);
    end
    n_cmp++;
    for (int r = 0; r < 4; r++) begin
      rd(1'b1);
      if (rd_data0 !== exp[r]) begin n_bad++; $display("FAIL coll_wrap_read%0d got %h want %h", r, rd_data0, exp[r]); end
      n_cmp++;
    end
    if (fill0 !== 9'd0) begin n_bad++; $display("FAIL coll_drained got %0d want 0", fill0); end
    n_cmp++;
    set_level(3'd6, 2);
    rd_sel = 1'b1;
    pulse(3);
    rd_sel = 1'b0;
    if (rd_data0 !== 16'hC205) begin n_bad++; $display("FAIL coll_empty_read got %h want C205", rd_data0); end
    n_cmp++;
    if (fill0 !== 9'd1 || pending0 !== 1'b1) begin
      n_bad++; $display("FAIL coll_empty_push fill %0d pending %b want 1 1", fill0, pending0);
    end
    n_cmp++;
  endtask

  initial begin
    reset = 1'b1; c7m = 1'b0; pi_rd = 1'b0; rd_sel = 1'b0; ipl_n = 3'b111;
    test_reset();
    test_basic();
    test_glitch();
    test_overflow();
    test_coalesce();
    test_collision();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
